move_link: RTL and testbench
============================

Name: move_link

Overview:
- Reliable move-exchange layer between game_fsm and the UART tx/rx pair.
- Wraps each outgoing 8-bit move in a sequenced two-byte packet, then waits for an ACK byte. Retransmits on timeout.
- On the receive side, parses incoming packets, drops duplicates, acknowledges every valid packet and presents each new move to game_fsm as a single-cycle pulse.

Parameters:
- BYTE_GAP, 70_000: clk_in cycles held after each tx_trigger before the next byte may be issued (≥10 bit times at 65 MHz/9600 baud).
- ACK_TIMEOUT, 6_500_000: cycles to wait for an ACK after the move byte's gap ends (100 ms).
- MAX_RETRY, 3: retransmissions allowed before link_err is declared.
- HDR_TIMEOUT, 140_000: cycles allowed between a received header and its move byte.

Ports:
- clk_in, input, 1: 65 MHz system clock.
- rst_in, input, 1: asynchronous, active-low reset.
- move_in, input, 8: move to send (row[7:4], col[3:0]; 8'hFF = pass).
- move_send, input, 1: one-cycle request to send move_in. Ignored while send_busy=1.
- send_busy, output, 1: high from the cycle after an accepted move_send until done or error.
- send_done, output, 1: one-cycle pulse when the matching ACK is received.
- link_err, output, 1: sticky; set after MAX_RETRY retransmissions fail. Cleared only by reset.
- tx_trigger, output, 1: one-cycle pulse to the tx module.
- tx_data, output, 8: byte for the tx module; held stable from the trigger cycle through the gap.
- rx_ready, input, 1: one-cycle strobe from rx with a new byte.
- rx_data, input, 8: byte from rx, valid when rx_ready=1.
- move_out, output, 8: last newly received move.
- move_valid, output, 1: one-cycle pulse when move_out updates with a non-duplicate move.

Behaviour:
- Wire formats:
  - Data packet: header 8'hA0|seq, then the raw move byte.
  - ACK: single byte 8'hC0|seq.
  - seq is 1 bit (bit 0).
- Reset values (asynchronous on rst_in=0):
  - All outputs 0; tx_data 8'h00.
  - tx_seq=0, rx_expect=0, ack_pend=0, retry=0.
  - Both FSMs idle; all counters 0.
- Tx byte slot:
  - gap counter is loaded with BYTE_GAP on every tx_trigger and decrements to 0.
  - A byte may be issued only when the counter is 0.
  - Priority when the slot is free: pending ACK first, then data-FSM bytes.
  - At most one tx_trigger per slot.
- Data FSM states: D_IDLE, D_HDR, D_MOVE, D_WAIT, D_ERR.
  - D_IDLE: move_send=1 latches move_in, clears retry, sets send_busy, goes to D_HDR.
  - D_HDR: when the slot is free and no ACK is pending, trigger 8'hA0|tx_seq, go to D_MOVE.
  - D_MOVE: when the slot is free and no ACK is pending, trigger the latched move, go to D_WAIT.
  - D_WAIT: the ack timer starts once the gap counter reaches 0.
    - rx byte == 8'hC0|tx_seq → send_done pulse, tx_seq toggles, send_busy=0, go to D_IDLE.
    - Timer reaches ACK_TIMEOUT with retry<MAX_RETRY → retry+1, go to D_HDR.
    - Timer reaches ACK_TIMEOUT with retry==MAX_RETRY → go to D_ERR.
    - An ACK with the wrong seq is ignored.
  - D_ERR: link_err=1 and send_busy=0. Terminal until reset.
- Rx FSM states: R_IDLE, R_HDR.
  - R_IDLE: byte 8'hA0|s latches s and goes to R_HDR. ACK bytes are routed to the data FSM. All other bytes are dropped.
  - R_HDR: the next rx byte is the move, whatever its value.
    - Set ack_pend with ack_seq=s.
    - If s==rx_expect: move_out<=byte, move_valid pulse, rx_expect toggles.
    - Otherwise it is a duplicate: ack it, no move_valid.
    - Return to R_IDLE.
  - R_HDR timeout: no byte for HDR_TIMEOUT cycles → return to R_IDLE with no ack.
- ACK sender: when ack_pend=1 and the slot is free, trigger 8'hC0|ack_seq and clear ack_pend. If a second packet completes before the ACK is sent, ack_seq is overwritten (latest wins).
- Simultaneous events:
  - move_send arriving in the same cycle as an rx move still accepts move_send.
  - An ACK pending in D_HDR/D_MOVE delays the data byte by one slot.
  - move_send while send_busy=1 or in D_ERR is dropped.
- Latency:
  - move_valid is asserted 1 cycle after the rx_ready carrying the move byte.
  - send_done is asserted 1 cycle after the matching ACK rx_ready.
  - The first tx_trigger occurs 1 cycle after move_send when idle.

Test Plan:
1. Reset, then move_send with move_in=8'h34; loop tx bytes back to a model that replies 8'hC0 → tx bytes A0, 34; send_done 1 cycle after the ACK; next send uses header A1.
2. No ACK ever returned → exactly 4 header/move pairs, each separated by BYTE_GAP+ACK_TIMEOUT; link_err=1, send_busy=0; later move_send ignored.
3. rx stream A0,52 → move_out=8'h52 with one move_valid pulse, tx C0; repeat A0,52 → no move_valid, tx C0 again; then A1,FF → move_valid, move_out=8'hFF, tx C1.
4. rx A1,33 arrives while the data FSM is in D_HDR → ACK C1 triggered before header A0; both separated by exactly BYTE_GAP cycles.
5. rx A0, then silence for HDR_TIMEOUT+1 cycles, then 8'h77 → no move_valid, no ACK; a stray 8'h12 in R_IDLE is ignored.
6. Assert rst_in=0 mid-D_WAIT after one retry → all outputs 0 asynchronously; after release, the next send uses header A0.

Source files
------------

// File: rtl/move_link_if.sv
`default_nettype none
// ============================================================================
//  Module      : move_link_if
//  Description : Signal bundle between move_link, game_fsm and the UART
//                tx/rx pair. The slave modport is the move_link view; the
//                master modport is the view of the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface move_link_if;
  // game_fsm side
  logic [7:0] move_in;
  logic       move_send;
  logic       send_busy;
  logic       send_done;
  logic       link_err;
  logic [7:0] move_out;
  logic       move_valid;
  // UART side
  logic       tx_trigger;
  logic [7:0] tx_data;
  logic       rx_ready;
  logic [7:0] rx_data;

  modport slave (
    input  move_in, move_send, rx_ready, rx_data,
    output send_busy, send_done, link_err, move_out, move_valid,
           tx_trigger, tx_data
  );

  modport master (
    output move_in, move_send, rx_ready, rx_data,
    input  send_busy, send_done, link_err, move_out, move_valid,
           tx_trigger, tx_data
  );
endinterface : move_link_if
`default_nettype wire

// File: rtl/move_link.sv
`default_nettype none
// ============================================================================
//  Module      : move_link
//  Description : Reliable move exchange over a UART byte link. Outgoing moves
//                are sent as a sequenced header + move byte pair and resent
//                until the matching ACK arrives or retries run out. Incoming
//                packets are acknowledged, duplicates are filtered, and each
//                new move is presented as a single-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module move_link #(
  parameter int BYTE_GAP    = 70_000,
  parameter int ACK_TIMEOUT = 6_500_000,
  parameter int MAX_RETRY   = 3,
  parameter int HDR_TIMEOUT = 140_000
) (
  input  wire logic  clk_in,
  input  wire logic  rst_in,
  move_link_if.slave bus
);

  localparam int c_gap_w   = $clog2(BYTE_GAP + 1);
  localparam int c_ack_w   = $clog2(ACK_TIMEOUT + 1);
  localparam int c_hdr_w   = $clog2(HDR_TIMEOUT + 1);
  localparam int c_retry_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Upper seven bits of the two framing bytes; bit 0 carries the sequence.
  localparam logic [6:0] c_hdr_tag = 7'b1010_000;
  localparam logic [6:0] c_ack_tag = 7'b1100_000;

  typedef enum logic [2:0] {
    D_IDLE = 3'd0,
    D_HDR  = 3'd1,
    D_MOVE = 3'd2,
    D_WAIT = 3'd3,
    D_ERR  = 3'd4
  } d_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_HDR  = 1'b1
  } r_state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  d_state_t               r_d_state;
  r_state_t               r_rx_state;

  logic [c_gap_w-1:0]     r_gap;
  logic                   r_tx_trigger;
  logic [7:0]             r_tx_data;

  logic                   r_ack_pend;
  logic                   r_ack_seq;

  logic                   r_tx_seq;
  logic [7:0]             r_move_buf;
  logic [c_retry_w-1:0]   r_retry;
  logic [c_ack_w-1:0]     r_ack_timer;
  logic                   r_send_busy;
  logic                   r_send_done;
  logic                   r_link_err;

  logic                   r_hdr_seq;
  logic                   r_rx_expect;
  logic [c_hdr_w-1:0]     r_hdr_timer;
  logic [7:0]             r_move_out;
  logic                   r_move_valid;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic       w_slot_free;
  logic       w_rx_is_hdr;
  logic       w_rx_is_ack;
  logic       w_ack_match;
  logic       w_pkt_done;
  logic       w_ack_issue;
  logic       w_data_req;
  logic [7:0] w_data_byte;
  logic       w_data_go;

  // tx_trigger is registered, so the issue decision is taken one cycle ahead
  // of the trigger. Treating a count of 1 as free keeps consecutive triggers
  // exactly BYTE_GAP cycles apart while the counter still loads BYTE_GAP.
  assign w_slot_free = (r_gap <= c_gap_w'(1));

  assign w_rx_is_hdr = bus.rx_ready && (r_rx_state == R_IDLE) &&
                       (bus.rx_data[7:1] == c_hdr_tag);
  assign w_rx_is_ack = bus.rx_ready && (r_rx_state == R_IDLE) &&
                       (bus.rx_data[7:1] == c_ack_tag);
  assign w_ack_match = w_rx_is_ack && (bus.rx_data[0] == r_tx_seq);

  // Any byte while a header is outstanding is the move byte, whatever value.
  assign w_pkt_done  = bus.rx_ready && (r_rx_state == R_HDR);

  assign w_ack_issue = r_ack_pend && w_slot_free;
  assign w_data_go   = w_data_req && w_slot_free && !r_ack_pend;

  // Byte the data FSM wants to put on the wire in its current state
  always_comb begin
    w_data_req  = 1'b0;
    w_data_byte = 8'h00;
    case (r_d_state)
      D_IDLE: begin
        // Lets the header go out in the same cycle the request is accepted.
        w_data_req  = bus.move_send;
        w_data_byte = {c_hdr_tag, r_tx_seq};
      end
      D_HDR: begin
        w_data_req  = 1'b1;
        w_data_byte = {c_hdr_tag, r_tx_seq};
      end
      D_MOVE: begin
        w_data_req  = 1'b1;
        w_data_byte = r_move_buf;
      end
      default: begin
        w_data_req  = 1'b0;
        w_data_byte = 8'h00;
      end
    endcase
  end

  // Tx byte slot: at most one trigger per gap, pending ACK ahead of data
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tx_trigger <= 1'b0;
      r_tx_data    <= 8'h00;
      r_gap        <= '0;
    end else begin
      r_tx_trigger <= 1'b0;
      if (w_ack_issue) begin
        r_tx_trigger <= 1'b1;
        r_tx_data    <= {c_ack_tag, r_ack_seq};
        r_gap        <= c_gap_w'(BYTE_GAP);
      end else if (w_data_go) begin
        r_tx_trigger <= 1'b1;
        r_tx_data    <= w_data_byte;
        r_gap        <= c_gap_w'(BYTE_GAP);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - c_gap_w'(1);
      end
    end
  end

  // ACK request: set by every completed packet, latest sequence wins
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_ack_pend <= 1'b0;
      r_ack_seq  <= 1'b0;
    end else begin
      if (w_ack_issue) begin
        r_ack_pend <= 1'b0;
      end
      // A packet finishing in the same cycle as an ACK leaves re-arms it.
      if (w_pkt_done) begin
        r_ack_pend <= 1'b1;
        r_ack_seq  <= r_hdr_seq;
      end
    end
  end

  // Data FSM: send header + move, wait for ACK, retry, give up
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_d_state   <= D_IDLE;
      r_tx_seq    <= 1'b0;
      r_move_buf  <= 8'h00;
      r_retry     <= '0;
      r_ack_timer <= '0;
      r_send_busy <= 1'b0;
      r_send_done <= 1'b0;
      r_link_err  <= 1'b0;
    end else begin
      r_send_done <= 1'b0;
      case (r_d_state)
        D_IDLE: begin
          if (bus.move_send) begin
            r_move_buf  <= bus.move_in;
            r_retry     <= '0;
            r_send_busy <= 1'b1;
            r_d_state   <= w_data_go ? D_MOVE : D_HDR;
          end
        end
        D_HDR: begin
          if (w_data_go) begin
            r_d_state <= D_MOVE;
          end
        end
        D_MOVE: begin
          if (w_data_go) begin
            r_ack_timer <= '0;
            r_d_state   <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (w_ack_match) begin
            r_send_done <= 1'b1;
            r_tx_seq    <= ~r_tx_seq;
            r_send_busy <= 1'b0;
            r_d_state   <= D_IDLE;
          end else if (w_slot_free) begin
            // The timer only runs once the move byte's gap has elapsed.
            if (r_ack_timer == c_ack_w'(ACK_TIMEOUT - 1)) begin
              r_ack_timer <= '0;
              if (r_retry == c_retry_w'(MAX_RETRY)) begin
                r_send_busy <= 1'b0;
                r_link_err  <= 1'b1;
                r_d_state   <= D_ERR;
              end else begin
                r_retry   <= r_retry + c_retry_w'(1);
                r_d_state <= D_HDR;
              end
            end else begin
              r_ack_timer <= r_ack_timer + c_ack_w'(1);
            end
          end
        end
        D_ERR: begin
          r_send_busy <= 1'b0;
          r_link_err  <= 1'b1;
        end
        default: begin
          r_d_state <= D_IDLE;
        end
      endcase
    end
  end

  // Rx FSM: parse header + move, filter duplicates, time out a lone header
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rx_state   <= R_IDLE;
      r_hdr_seq    <= 1'b0;
      r_rx_expect  <= 1'b0;
      r_hdr_timer  <= '0;
      r_move_out   <= 8'h00;
      r_move_valid <= 1'b0;
    end else begin
      r_move_valid <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          r_hdr_timer <= '0;
          if (w_rx_is_hdr) begin
            r_hdr_seq  <= bus.rx_data[0];
            r_rx_state <= R_HDR;
          end
        end
        R_HDR: begin
          if (bus.rx_ready) begin
            if (r_hdr_seq == r_rx_expect) begin
              r_move_out   <= bus.rx_data;
              r_move_valid <= 1'b1;
              r_rx_expect  <= ~r_rx_expect;
            end
            r_rx_state <= R_IDLE;
          end else if (r_hdr_timer == c_hdr_w'(HDR_TIMEOUT - 1)) begin
            r_rx_state <= R_IDLE;
          end else begin
            r_hdr_timer <= r_hdr_timer + c_hdr_w'(1);
          end
        end
        default: begin
          r_rx_state <= R_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign bus.send_busy  = r_send_busy;
  assign bus.send_done  = r_send_done;
  assign bus.link_err   = r_link_err;
  assign bus.tx_trigger = r_tx_trigger;
  assign bus.tx_data    = r_tx_data;
  assign bus.move_out   = r_move_out;
  assign bus.move_valid = r_move_valid;

endmodule : move_link
`default_nettype wire

// File: tb/tb_move_link.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_link
//  Description : Self-checking bench for move_link. Stimulus pushes expected
//                tx bytes and received moves into queues; a monitor pops and
//                compares them whenever the DUT triggers a byte or a move.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_move_link;

  localparam int G = 16;   // BYTE_GAP
  localparam int T = 60;   // ACK_TIMEOUT
  localparam int R = 3;    // MAX_RETRY
  localparam int H = 30;   // HDR_TIMEOUT

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  move_link_if bus();

  move_link #(
    .BYTE_GAP    (G),
    .ACK_TIMEOUT (T),
    .MAX_RETRY   (R),
    .HDR_TIMEOUT (H)
  ) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_trig   = 0;
  int         n_mv     = 0;
  int         cyc      = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_mv[$];
  int         tx_time[$];
  bit         m_tx_seq    = 1'b0;   // peer-visible sequence of our next packet
  bit         m_rx_expect = 1'b0;   // sequence of the next new incoming packet

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [7:0] hdr_b(input bit s);
    return 8'hA0 + {7'd0, s};
  endfunction

  function automatic logic [7:0] ack_b(input bit s);
    return 8'hC0 + {7'd0, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        if (bus.tx_trigger) begin
          n_trig++;
          tx_time.push_back(cyc);
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected actual=%02h required=none", bus.tx_data);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, e});
          end
        end
        if (bus.move_valid) begin
          n_mv++;
          if (exp_mv.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL move_unexpected actual=%02h required=none", bus.move_out);
          end else begin
            e = exp_mv.pop_front();
            chk("move_out", {24'd0, bus.move_out}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk_in);
    bus.rx_ready = 1'b0;
  endtask

  task automatic pulse_send(input logic [7:0] mv);
    bus.move_in   = mv;
    bus.move_send = 1'b1;
    @(negedge clk_in);
    bus.move_send = 1'b0;
  endtask

  task automatic wait_trig(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_trig < target && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    chk(name, n_trig, target);
  endtask

  // One outgoing move, answered by the bench acting as the peer
  task automatic do_send(input logic [7:0] mv, input bit wrong_first);
    int base;
    idle(G + 2);
    exp_tx.push_back(hdr_b(m_tx_seq));
    exp_tx.push_back(mv);
    base = n_trig;
    pulse_send(mv);
    chk("first_trig_latency", bus.tx_trigger, 1);
    chk("busy_after_send", bus.send_busy, 1);
    wait_trig(base + 2, 3 * G, "data_bytes_sent");
    idle($urandom_range(0, 4));
    if (wrong_first) begin
      rx_byte(ack_b(!m_tx_seq));
      chk("wrong_ack_no_done", bus.send_done, 0);
      chk("wrong_ack_busy", bus.send_busy, 1);
    end
    rx_byte(ack_b(m_tx_seq));
    chk("done_latency", bus.send_done, 1);
    chk("busy_clear", bus.send_busy, 0);
    @(negedge clk_in);
    chk("done_one_cycle", bus.send_done, 0);
    m_tx_seq = !m_tx_seq;
  endtask

  // One incoming packet from the peer
  task automatic rx_packet(input bit s, input logic [7:0] mv);
    int base;
    bit fresh;
    idle(G + 2);
    fresh = (s == m_rx_expect);
    if (fresh) begin
      exp_mv.push_back(mv);
      m_rx_expect = !m_rx_expect;
    end
    exp_tx.push_back(ack_b(s));
    base = n_trig;
    rx_byte(hdr_b(s));
    idle($urandom_range(0, H / 2));
    rx_byte(mv);
    chk("move_valid_latency", bus.move_valid, fresh);
    wait_trig(base + 1, G, "ack_sent");
  endtask

  initial begin
    int base;
    int b;
    bit s1;
    bit s2;
    logic [7:0] mv;
    logic [7:0] mvd;

    bus.move_in   = 8'h00;
    bus.move_send = 1'b0;
    bus.rx_ready  = 1'b0;
    bus.rx_data   = 8'h00;

    // Reset state
    idle(3);
    chk("rst_send_busy", bus.send_busy, 0);
    chk("rst_send_done", bus.send_done, 0);
    chk("rst_link_err", bus.link_err, 0);
    chk("rst_tx_trigger", bus.tx_trigger, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_move_out", bus.move_out, 0);
    chk("rst_move_valid", bus.move_valid, 0);
    rst_in = 1'b1;
    idle(2);

    // Outgoing moves with ACKs, first one fixed, header alternates
    do_send(8'h34, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_send(8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Incoming packets: new, duplicate, new pass move, then random
    rx_packet(1'b0, 8'h52);
    rx_packet(1'b0, 8'h52);
    rx_packet(1'b1, 8'hFF);
    chk("move_out_pass", bus.move_out, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      rx_packet(1'($urandom_range(0, 1)), 8'($urandom));
    end

    // ACK pending while a header waits for the slot goes out first
    idle(G + 2);
    b    = tx_time.size();
    base = n_trig;
    s1   = m_rx_expect;
    mv   = 8'($urandom);
    exp_tx.push_back(ack_b(s1));
    exp_mv.push_back(mv);
    m_rx_expect = !m_rx_expect;
    rx_byte(hdr_b(s1));
    rx_byte(mv);
    wait_trig(base + 1, G, "t4_first_ack");
    s2  = m_rx_expect;
    mvd = 8'($urandom);
    exp_tx.push_back(ack_b(s2));
    exp_tx.push_back(hdr_b(m_tx_seq));
    exp_tx.push_back(mvd);
    exp_mv.push_back(8'h33);
    m_rx_expect = !m_rx_expect;
    pulse_send(mvd);
    chk("t4_header_held", bus.tx_trigger, 0);
    chk("t4_busy", bus.send_busy, 1);
    rx_byte(hdr_b(s2));
    rx_byte(8'h33);
    chk("t4_move_valid", bus.move_valid, 1);
    wait_trig(base + 4, 4 * G, "t4_all_bytes");
    if (tx_time.size() >= b + 3) begin
      chk("t4_ack_to_ack_gap", tx_time[b + 1] - tx_time[b], G);
      chk("t4_ack_to_hdr_gap", tx_time[b + 2] - tx_time[b + 1], G);
    end
    rx_byte(ack_b(m_tx_seq));
    chk("t4_send_done", bus.send_done, 1);
    m_tx_seq = !m_tx_seq;

    // Header timeout, then stray bytes are ignored
    idle(G + 2);
    base = n_trig;
    b    = n_mv;
    rx_byte(hdr_b(m_rx_expect));
    idle(H + 1);
    rx_byte(8'h77);
    chk("hdr_timeout_no_valid", bus.move_valid, 0);
    idle(G + 4);
    chk("hdr_timeout_no_ack", n_trig, base);
    chk("hdr_timeout_no_move", n_mv, b);
    rx_byte(8'h12);
    idle(G + 4);
    chk("stray_no_ack", n_trig, base);
    chk("stray_no_move", n_mv, b);
    rx_packet(m_rx_expect, 8'h5A);

    // No ACK at all: initial send plus MAX_RETRY resends, then link_err
    idle(G + 2);
    mv   = 8'($urandom);
    b    = tx_time.size();
    base = n_trig;
    for (int k = 0; k <= R; k++) begin
      exp_tx.push_back(hdr_b(m_tx_seq));
      exp_tx.push_back(mv);
    end
    pulse_send(mv);
    wait_trig(base + 2 * (R + 1), (R + 1) * (2 * G + T) + 20, "retry_bytes");
    chk("retry_not_err_yet", bus.link_err, 0);
    chk("retry_still_busy", bus.send_busy, 1);
    if (tx_time.size() >= b + 2 * (R + 1)) begin
      for (int k = 0; k <= R; k++) begin
        chk("retry_hdr_to_move", tx_time[b + 2 * k + 1] - tx_time[b + 2 * k], G);
        if (k < R) begin
          chk("retry_move_to_hdr", tx_time[b + 2 * k + 2] - tx_time[b + 2 * k + 1], G + T);
        end
      end
    end
    begin
      int k;
      k = 0;
      while (!bus.link_err && k < 2 * (G + T)) begin
        @(negedge clk_in);
        k++;
      end
    end
    chk("link_err_set", bus.link_err, 1);
    chk("err_busy_low", bus.send_busy, 0);
    pulse_send(8'($urandom));
    idle(2 * G + T);
    chk("err_send_dropped", n_trig, base + 2 * (R + 1));
    chk("err_busy_stays_low", bus.send_busy, 0);
    chk("err_sticky", bus.link_err, 1);

    rst_in = 1'b0;
    #1;
    chk("reset_clears_err", bus.link_err, 0);
    m_tx_seq    = 1'b0;
    m_rx_expect = 1'b0;
    idle(2);
    rst_in = 1'b1;

    // Asynchronous reset in the middle of an ACK wait after one retry
    do_send(8'($urandom), 1'b0);
    idle(G + 2);
    mv   = 8'($urandom) | 8'h01;
    base = n_trig;
    for (int k = 0; k < 2; k++) begin
      exp_tx.push_back(hdr_b(m_tx_seq));
      exp_tx.push_back(mv);
    end
    pulse_send(mv);
    wait_trig(base + 4, 2 * (2 * G + T) + 20, "t6_retry_bytes");
    idle(G + 5);
    chk("t6_busy_before_rst", bus.send_busy, 1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_async_busy", bus.send_busy, 0);
    chk("t6_async_tx_data", bus.tx_data, 0);
    chk("t6_async_trigger", bus.tx_trigger, 0);
    chk("t6_async_err", bus.link_err, 0);
    chk("t6_async_done", bus.send_done, 0);
    chk("t6_async_move_out", bus.move_out, 0);
    chk("t6_async_valid", bus.move_valid, 0);
    m_tx_seq    = 1'b0;
    m_rx_expect = 1'b0;
    idle(2);
    rst_in = 1'b1;
    do_send(8'($urandom), 1'b0);
    rx_packet(1'b0, 8'($urandom));

    idle(G + 4);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("move_queue_drained", exp_mv.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_move_link
`default_nettype wire
